decoder_fault_monitor: RTL and testbench

DECODER_FAULT_MONITOR -- requirements
Module: decoder_fault_monitor

---
 rtl/decoder_fault_pkg.sv | 21 ++
 rtl/decoder_fault_monitor_onehot_check.sv | 12 +
 rtl/decoder_fault_monitor.sv | 144 ++++++++++++++
 tb/tb_decoder_fault_monitor.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_fault_pkg.sv
// Shared types and constants for the decoder fault monitor: FSM states,
// code/line widths and the default confirmation depth.
package decoder_fault_pkg;

   localparam int CODE_W                 = 2;
   localparam int LINE_W                 = 4;
   localparam int MISS_W                 = 4;
   localparam int CONFIRM_CYCLES_DEFAULT = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CHECK   = 2'd1,
      SUSPECT = 2'd2,
      FAULT   = 2'd3
   } state_t;

   function automatic logic [LINE_W-1:0] decode_code(input logic [CODE_W-1:0] code);
      return LINE_W'(1) << code;
   endfunction

endpackage

// File: rtl/decoder_fault_monitor_onehot_check.sv
// Combinational one-hot validity test of the decoder line readback.
module onehot_check
   import decoder_fault_pkg::*;
(
   input  logic [LINE_W-1:0] lines,
   output logic              onehot
);

   // x & (x-1) clears the lowest set bit; zero result means at most one bit set
   assign onehot = (lines != '0) && ((lines & (lines - LINE_W'(1))) == '0);

endmodule

// File: rtl/decoder_fault_monitor.sv
// Registered 2-to-4 decoder with readback fault confirmation FSM.
// Optional input parity checking is enabled by defining DECODER_PARITY_EN.
module decoder_fault_monitor
   import decoder_fault_pkg::*;
#(
   parameter int CONFIRM_CYCLES = CONFIRM_CYCLES_DEFAULT,
   parameter int CNT_W          = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_in,
   input  logic [CODE_W-1:0]     Y,
   output logic [LINE_W-1:0]     D,
   output logic                  valid_out,
   input  logic [LINE_W-1:0]     D_fb,
   input  logic                  clear,
   output logic                  fault_detected,
   output logic                  fault_sticky,
   output logic [CNT_W-1:0]      fault_count
`ifdef DECODER_PARITY_EN
   ,
   input  logic                  par_in,
   output logic                  parity_err
`endif
);

   state_t             state;
   logic [MISS_W-1:0]  miss_cnt;
   logic [MISS_W-1:0]  miss_inc;
   logic [LINE_W-1:0]  d_next;
   logic               accept;
   logic               d_change;
   logic               blank_p1;
   logic               fb_onehot;
   logic               mismatch;
   logic               cmp_en;
   logic               enter_fault;

`ifdef DECODER_PARITY_EN
   // Even parity: Y and par_in together must carry an even number of ones
   assign accept = valid_in && !(^{Y, par_in});
`else
   assign accept = valid_in;
`endif

   assign d_next   = decode_code(Y);
   assign d_change = accept && (d_next != D);
   assign cmp_en   = (state != IDLE) && !blank_p1;
   assign mismatch = (D_fb != D) || !fb_onehot;
   assign miss_inc = miss_cnt + MISS_W'(1);

   assign enter_fault = cmp_en && mismatch &&
                        (((state == CHECK) && (CONFIRM_CYCLES == 1)) ||
                         ((state == SUSPECT) && (miss_inc == MISS_W'(CONFIRM_CYCLES))));

   onehot_check u_onehot_check (
      .lines  (D_fb),
      .onehot (fb_onehot)
   );

   // Stage p1: decoder output register and blanking flag for the readback path
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         D         <= '0;
         valid_out <= 1'b0;
         blank_p1  <= 1'b0;
      end else begin
         valid_out <= accept;
         blank_p1  <= d_change;
         if (accept)
            D <= d_next;
      end
   end

`ifdef DECODER_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         parity_err <= 1'b0;
      else
         parity_err <= valid_in && !accept;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         miss_cnt       <= '0;
         fault_detected <= 1'b0;
      end else if (state == IDLE) begin
         if (accept)
            state <= CHECK;
      end else if (cmp_en) begin
         case (state)
            CHECK: begin
               if (mismatch) begin
                  miss_cnt <= MISS_W'(1);
                  if (CONFIRM_CYCLES == 1) begin
                     state          <= FAULT;
                     fault_detected <= 1'b1;
                  end else begin
                     state <= SUSPECT;
                  end
               end
            end
            SUSPECT: begin
               if (mismatch) begin
                  miss_cnt <= miss_inc;
                  if (miss_inc == MISS_W'(CONFIRM_CYCLES)) begin
                     state          <= FAULT;
                     fault_detected <= 1'b1;
                  end
               end else begin
                  miss_cnt <= '0;
                  state    <= CHECK;
               end
            end
            FAULT: begin
               if (!mismatch) begin
                  miss_cnt       <= '0;
                  state          <= CHECK;
                  fault_detected <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A fault entry in the same cycle as clear keeps the sticky flag set
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault_sticky <= 1'b0;
         fault_count  <= '0;
      end else begin
         if (enter_fault)
            fault_sticky <= 1'b1;
         else if (clear)
            fault_sticky <= 1'b0;
         if (enter_fault && (fault_count != '1))
            fault_count <= fault_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_decoder_fault_monitor.sv
// Scoreboard bench for decoder_fault_monitor; parity scenario is built when
// DECODER_PARITY_EN is defined.
module tb_decoder_fault_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid_in;
   logic [1:0] Y;
   logic [3:0] D;
   logic       valid_out;
   logic [3:0] D_fb;
   logic       clear;
   logic       fault_detected;
   logic       fault_sticky;
   logic [1:0] fault_count;
`ifdef DECODER_PARITY_EN
   logic       par_in;
   logic       parity_err;
`endif

   int         checks = 0;
   int         passes = 0;
   logic [3:0] sb[$];
   logic [1:0] exp_count = 2'd0;

   always #5 clk = ~clk;

   decoder_fault_monitor #(
      .CONFIRM_CYCLES (3),
      .CNT_W          (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .valid_in       (valid_in),
      .Y              (Y),
      .D              (D),
      .valid_out      (valid_out),
      .D_fb           (D_fb),
      .clear          (clear),
      .fault_detected (fault_detected),
      .fault_sticky   (fault_sticky),
      .fault_count    (fault_count)
`ifdef DECODER_PARITY_EN
      ,
      .par_in         (par_in),
      .parity_err     (parity_err)
`endif
   );

   // Every valid_out pulse must match the oldest expected decode
   always @(negedge clk) begin
      if (!rst && valid_out) begin
         logic [3:0] exp_d;
         checks = checks + 1;
         if (sb.size() == 0) begin
            $display("FAIL sb_unexpected valid_out with D=%b, nothing expected", D);
         end else begin
            exp_d = sb.pop_front();
            if (D !== exp_d)
               $display("FAIL sb_decode got D=%b expected %b", D, exp_d);
            else
               passes = passes + 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] y);
      valid_in = 1'b1;
      Y        = y;
`ifdef DECODER_PARITY_EN
      par_in   = ^y;
`endif
      sb.push_back(4'b0001 << y);
      step();
      valid_in = 1'b0;
   endtask

   function automatic logic [1:0] sat_inc(input logic [1:0] v);
      return (v == 2'd3) ? 2'd3 : v + 2'd1;
   endfunction

   task automatic test_reset();
      rst = 1'b1; valid_in = 1'b0; Y = 2'd0; D_fb = 4'd0; clear = 1'b0;
`ifdef DECODER_PARITY_EN
      par_in = 1'b0;
`endif
      #3;
      checks++; if (D !== 4'b0000) $display("FAIL reset_D got %b expected 0000", D); else passes++;
      checks++; if (valid_out !== 1'b0) $display("FAIL reset_valid_out got %b expected 0", valid_out); else passes++;
      checks++; if (fault_detected !== 1'b0) $display("FAIL reset_fault got %b expected 0", fault_detected); else passes++;
      checks++; if (fault_sticky !== 1'b0) $display("FAIL reset_sticky got %b expected 0", fault_sticky); else passes++;
      checks++; if (fault_count !== 2'd0) $display("FAIL reset_count got %0d expected 0", fault_count); else passes++;
      step(); step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_decode();
      for (int y = 0; y < 4; y++) begin
         send(2'(y));
         D_fb = 4'b0001 << y;
         checks++; if (D !== (4'b0001 << y)) $display("FAIL decode_D y=%0d got %b expected %b", y, D, 4'b0001 << y); else passes++;
         checks++; if (fault_detected !== 1'b0) $display("FAIL decode_fault y=%0d got %b expected 0", y, fault_detected); else passes++;
      end
      repeat (3) step();
      checks++; if (valid_out !== 1'b0) $display("FAIL hold_valid_out got %b expected 0", valid_out); else passes++;
      checks++; if (D !== 4'b1000) $display("FAIL hold_D got %b expected 1000", D); else passes++;
      checks++; if (fault_detected !== 1'b0) $display("FAIL hold_fault got %b expected 0", fault_detected); else passes++;
   endtask

   task automatic test_confirm();
      send(2'd2);
      D_fb = 4'b0000;
      step();
      checks++; if (fault_detected !== 1'b0) $display("FAIL confirm_blank got %b expected 0", fault_detected); else passes++;
      step(); step();
      checks++; if (fault_detected !== 1'b0) $display("FAIL confirm_early got %b expected 0", fault_detected); else passes++;
      step();
      exp_count = sat_inc(exp_count);
      checks++; if (fault_detected !== 1'b1) $display("FAIL confirm_fault got %b expected 1", fault_detected); else passes++;
      checks++; if (fault_count !== exp_count) $display("FAIL confirm_count got %0d expected %0d", fault_count, exp_count); else passes++;
      checks++; if (fault_sticky !== 1'b1) $display("FAIL confirm_sticky got %b expected 1", fault_sticky); else passes++;
   endtask

   task automatic test_recover_clear();
      D_fb = 4'b0100;
      step();
      checks++; if (fault_detected !== 1'b0) $display("FAIL recover_fault got %b expected 0", fault_detected); else passes++;
      checks++; if (fault_sticky !== 1'b1) $display("FAIL recover_sticky got %b expected 1", fault_sticky); else passes++;
      clear = 1'b1;
      step();
      clear = 1'b0;
      checks++; if (fault_sticky !== 1'b0) $display("FAIL clear_sticky got %b expected 0", fault_sticky); else passes++;
      checks++; if (fault_count !== exp_count) $display("FAIL clear_count got %0d expected %0d", fault_count, exp_count); else passes++;
   endtask

   task automatic test_glitch();
      D_fb = 4'b0110; step(); step();
      D_fb = 4'b0100; step();
      D_fb = 4'b0110; step(); step();
      checks++; if (fault_detected !== 1'b0) $display("FAIL glitch_fault got %b expected 0", fault_detected); else passes++;
      D_fb = 4'b0100; step();
      checks++; if (fault_count !== exp_count) $display("FAIL glitch_count got %0d expected %0d", fault_count, exp_count); else passes++;
   endtask

   task automatic test_blank_hold();
      D_fb = 4'b0000;
      step();
      send(2'd1);
      step();
      checks++; if (fault_detected !== 1'b0) $display("FAIL blank_advance got %b expected 0", fault_detected); else passes++;
      step();
      exp_count = sat_inc(exp_count);
      checks++; if (fault_detected !== 1'b1) $display("FAIL blank_reset got %b expected 1", fault_detected); else passes++;
      checks++; if (fault_count !== exp_count) $display("FAIL blank_count got %0d expected %0d", fault_count, exp_count); else passes++;
      D_fb = 4'b0010;
      step();
   endtask

   task automatic test_clear_vs_set();
      clear = 1'b1; step(); clear = 1'b0;
      checks++; if (fault_sticky !== 1'b0) $display("FAIL cvs_pre_sticky got %b expected 0", fault_sticky); else passes++;
      D_fb = 4'b1010; step(); step();
      clear = 1'b1; step(); clear = 1'b0;
      exp_count = sat_inc(exp_count);
      checks++; if (fault_sticky !== 1'b1) $display("FAIL cvs_sticky got %b expected 1", fault_sticky); else passes++;
      checks++; if (fault_detected !== 1'b1) $display("FAIL cvs_fault got %b expected 1", fault_detected); else passes++;
      checks++; if (fault_count !== exp_count) $display("FAIL cvs_count got %0d expected %0d", fault_count, exp_count); else passes++;
      D_fb = 4'b0010; step();
   endtask

   task automatic test_saturate();
      D_fb = 4'b0001;
      repeat (3) step();
      exp_count = sat_inc(exp_count);
      checks++; if (fault_detected !== 1'b1) $display("FAIL sat_fault got %b expected 1", fault_detected); else passes++;
      checks++; if (fault_count !== exp_count) $display("FAIL sat_count got %0d expected %0d", fault_count, exp_count); else passes++;
      D_fb = 4'b0010; step();
   endtask

   task automatic test_reset_mid();
      D_fb = 4'b0000; step(); step();
      #2; rst = 1'b1; #1;
      exp_count = 2'd0;
      checks++; if (D !== 4'b0000) $display("FAIL rmid_D got %b expected 0000", D); else passes++;
      checks++; if (fault_detected !== 1'b0) $display("FAIL rmid_fault got %b expected 0", fault_detected); else passes++;
      checks++; if (fault_sticky !== 1'b0) $display("FAIL rmid_sticky got %b expected 0", fault_sticky); else passes++;
      checks++; if (fault_count !== exp_count) $display("FAIL rmid_count got %0d expected 0", fault_count); else passes++;
      step(); rst = 1'b0;
      D_fb = 4'b0101;
      repeat (5) step();
      checks++; if (fault_detected !== 1'b0) $display("FAIL idle_ignore got %b expected 0", fault_detected); else passes++;
      send(2'd0);
      D_fb = 4'b0000;
      repeat (4) step();
      exp_count = sat_inc(exp_count);
      checks++; if (fault_detected !== 1'b1) $display("FAIL rearm_fault got %b expected 1", fault_detected); else passes++;
      checks++; if (fault_count !== exp_count) $display("FAIL rearm_count got %0d expected %0d", fault_count, exp_count); else passes++;
      D_fb = 4'b0001; step();
   endtask

`ifdef DECODER_PARITY_EN
   task automatic test_parity();
      valid_in = 1'b1; Y = 2'b01; par_in = 1'b0;
      step();
      valid_in = 1'b0;
      checks++; if (parity_err !== 1'b1) $display("FAIL par_err got %b expected 1", parity_err); else passes++;
      checks++; if (D !== 4'b0001) $display("FAIL par_drop_D got %b expected 0001", D); else passes++;
      step();
      checks++; if (parity_err !== 1'b0) $display("FAIL par_pulse got %b expected 0", parity_err); else passes++;
      send(2'b01);
      D_fb = 4'b0010;
      checks++; if (D !== 4'b0010) $display("FAIL par_ok_D got %b expected 0010", D); else passes++;
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_decode();
      test_confirm();
      test_recover_clear();
      test_glitch();
      test_blank_hold();
      test_clear_vs_set();
      test_saturate();
      test_reset_mid();
`ifdef DECODER_PARITY_EN
      test_parity();
`endif
      step(); step();
      checks++; if (sb.size() != 0) $display("FAIL sb_drain got %0d pending expected 0", sb.size()); else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout simulation exceeded 100000 time units");
      $fatal(1, "timeout");
   end

endmodule
